// File: rtl/led_pattern_sequencer.sv
// Front-panel LED pattern sequencer: four debounced push switches select,
// pause and re-time one of four LED patterns paced by a shared prescaler.
// Optional build macro LED_SEQ_HEARTBEAT_EN: when defined, mode 0 toggles
// o_LED_4 on every step instead of staying fully dark.
module led_pattern_sequencer #(
  parameter int unsigned TICK_CLKS     = 2500000,
  parameter int unsigned DEBOUNCE_CLKS = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  input  logic i_Switch_3,
  input  logic i_Switch_4,
  output logic o_LED_1,
  output logic o_LED_2,
  output logic o_LED_3,
  output logic o_LED_4
);

  localparam int unsigned PRE_W = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CLKS + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CLKS - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CLKS - 1);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  // Switch path: bit0 = SW1 (next), bit1 = SW2 (prev), bit2 = SW3 (pause), bit3 = SW4 (speed)
  logic [3:0]       sw_raw;
  logic [3:0]       sync_a;
  logic [3:0]       sync_b;
  logic [3:0]       deb_state;
  logic [3:0]       deb_prev;
  logic [3:0]       press;
  logic [DEB_W-1:0] deb_cnt [4];

  mode_t            mode, mode_nxt;
  logic             paused;
  logic [1:0]       speed;
  logic [PRE_W-1:0] pre;
  logic [2:0]       rate;
  logic [2:0]       rate_last;
  logic [3:0]       pattern, pattern_nxt;
  logic             dir_up, dir_nxt;
  logic             mode_chg;
  logic             base_tick;
  logic             step;

  assign sw_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  // Two-flop synchroniser for the asynchronous switch inputs
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= sw_raw;
      sync_b <= sync_a;
    end
  end

  // Debouncers: accept a new level only after it has differed for DEBOUNCE_CLKS cycles
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      deb_state <= '0;
      deb_prev  <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      deb_prev <= deb_state;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync_b[i] == deb_state[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_state[i] <= ~deb_state[i];
          deb_cnt[i]   <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Press strobes, timing taps and next mode/pattern selection
  always_comb begin
    press       = deb_state & ~deb_prev;
    mode_chg    = press[0] ^ press[1];
    base_tick   = !paused && (pre == PRE_LAST);
    rate_last   = 3'd0;
    case (speed)
      2'd0:    rate_last = 3'd0;
      2'd1:    rate_last = 3'd1;
      2'd2:    rate_last = 3'd3;
      default: rate_last = 3'd7;
    endcase
    step        = base_tick && (rate == rate_last);
    mode_nxt    = mode;
    pattern_nxt = pattern;
    dir_nxt     = dir_up;

    if (press[0] && !press[1]) begin
      mode_nxt = mode_t'(mode + 2'd1);
    end else if (press[1] && !press[0]) begin
      mode_nxt = mode_t'(mode - 2'd1);
    end

    if (mode_chg) begin
      dir_nxt = 1'b1;
      case (mode_nxt)
        MODE_OFF:    pattern_nxt = 4'b0000;
        MODE_BLINK:  pattern_nxt = 4'b0000;
        MODE_CHASE:  pattern_nxt = 4'b0001;
        default:     pattern_nxt = 4'b0001;
      endcase
    end else if (step) begin
      case (mode)
        MODE_OFF: begin
`ifdef LED_SEQ_HEARTBEAT_EN
          pattern_nxt = {~pattern[3], 3'b000};
`else
          pattern_nxt = 4'b0000;
`endif
        end
        MODE_BLINK: pattern_nxt = ~pattern;
        MODE_CHASE: pattern_nxt = {pattern[2:0], pattern[3]};
        default: begin
          // Ping-pong: reverse at either end rather than wrapping
          if (dir_up) begin
            if (pattern[3]) begin
              pattern_nxt = 4'b0100;
              dir_nxt     = 1'b0;
            end else begin
              pattern_nxt = {pattern[2:0], 1'b0};
            end
          end else begin
            if (pattern[0]) begin
              pattern_nxt = 4'b0010;
              dir_nxt     = 1'b1;
            end else begin
              pattern_nxt = {1'b0, pattern[3:1]};
            end
          end
        end
      endcase
    end
  end

  // Mode, pattern and bounce direction registers
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      mode    <= MODE_OFF;
      pattern <= '0;
      dir_up  <= 1'b1;
    end else begin
      mode    <= mode_nxt;
      pattern <= pattern_nxt;
      dir_up  <= dir_nxt;
    end
  end

  // Pause toggle and speed select
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      paused <= 1'b0;
      speed  <= '0;
    end else begin
      if (press[2]) paused <= ~paused;
      if (press[3]) speed  <= speed + 2'd1;
    end
  end

  // Prescaler and rate counter; a mode change restarts the step phase
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      pre  <= '0;
      rate <= '0;
    end else begin
      if (mode_chg) begin
        pre <= '0;
      end else if (!paused) begin
        pre <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
      end

      if (mode_chg || press[3]) begin
        rate <= '0;
      end else if (base_tick) begin
        rate <= step ? '0 : rate + 3'd1;
      end
    end
  end

  assign o_LED_1 = pattern[0];
  assign o_LED_2 = pattern[1];
  assign o_LED_3 = pattern[2];
  assign o_LED_4 = pattern[3];

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed table-driven bench for led_pattern_sequencer (TICK_CLKS=4, DEBOUNCE_CLKS=3).
// Each row: optional async reset pulse, optional switch press, idle cycles, LED check.
// A press returns on the negedge just after the edge where it takes effect (6 edges).
module tb_led_pattern_sequencer;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic [3:0] sw    = '0;
  logic       o_LED_1, o_LED_2, o_LED_3, o_LED_4;
  logic [3:0] leds;

  int unsigned passed = 0;
  int unsigned total  = 0;

  typedef struct {
    bit          do_rst;
    logic [3:0]  sw;
    int unsigned hold;
    int unsigned wait_cyc;
    logic [3:0]  exp_dark;
    logic [3:0]  exp_hb;
    string       name;
  } vec_t;

  vec_t vecs[$];

  led_pattern_sequencer #(.TICK_CLKS(4), .DEBOUNCE_CLKS(3)) dut (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Switch_1(sw[0]),
    .i_Switch_2(sw[1]),
    .i_Switch_3(sw[2]),
    .i_Switch_4(sw[3]),
    .o_LED_1   (o_LED_1),
    .o_LED_2   (o_LED_2),
    .o_LED_3   (o_LED_3),
    .o_LED_4   (o_LED_4)
  );

  assign leds = {o_LED_4, o_LED_3, o_LED_2, o_LED_1};

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: leds=%b expected=%b at %0t", name, got, exp, $time);
  endtask

  task automatic press(input logic [3:0] mask, input int unsigned hold);
    sw = mask;
    repeat (hold) @(negedge i_Clk);
    sw = '0;
    repeat (6 - hold) @(negedge i_Clk);
  endtask

  function automatic void add(input bit r, input logic [3:0] s, input int unsigned h,
                              input int unsigned w, input logic [3:0] ed,
                              input logic [3:0] eh, input string n);
    vec_t v;
    v.do_rst = r; v.sw = s; v.hold = h; v.wait_cyc = w;
    v.exp_dark = ed; v.exp_hb = eh; v.name = n;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [3:0] exp;
    // Mode 2 run, then reset and blink
    add(0, 4'b0001, 4, 0, 4'b0000, 4'b0000, "blink_load");
    add(0, 4'b0000, 0, 4, 4'b1111, 4'b1111, "blink_step1");
    add(0, 4'b0000, 0, 4, 4'b0000, 4'b0000, "blink_step2");
    add(0, 4'b0001, 4, 0, 4'b0001, 4'b0001, "chase_load");
    add(0, 4'b0000, 0, 4, 4'b0010, 4'b0010, "chase_1");
    add(0, 4'b0000, 0, 4, 4'b0100, 4'b0100, "chase_2");
    add(1, 4'b0001, 4, 0, 4'b0000, 4'b0000, "rst_then_blink_load");
    add(0, 4'b0000, 0, 4, 4'b1111, 4'b1111, "rst_blink_step1");
    add(0, 4'b0000, 0, 4, 4'b0000, 4'b0000, "rst_blink_step2");
    // Debounce
    add(0, 4'b0010, 4, 2, 4'b0000, 4'b0000, "to_off");
    add(0, 4'b0001, 2, 6, 4'b0000, 4'b1000, "glitch_2cyc_ignored");
    add(0, 4'b0001, 6, 0, 4'b0000, 4'b0000, "hold_6cyc_load");
    add(0, 4'b0000, 0, 4, 4'b1111, 4'b1111, "hold_6cyc_once");
    // Wrap 0 -> 3 and bounce at speed 0
    add(0, 4'b0010, 4, 2, 4'b0000, 4'b0000, "back_to_off");
    add(0, 4'b0010, 4, 0, 4'b0001, 4'b0001, "wrap_0_to_3");
    add(0, 4'b0000, 0, 4, 4'b0010, 4'b0010, "bounce_1");
    add(0, 4'b0000, 0, 4, 4'b0100, 4'b0100, "bounce_2");
    add(0, 4'b0000, 0, 4, 4'b1000, 4'b1000, "bounce_3");
    add(0, 4'b0000, 0, 4, 4'b0100, 4'b0100, "bounce_4");
    add(0, 4'b0000, 0, 4, 4'b0010, 4'b0010, "bounce_5");
    add(0, 4'b0000, 0, 4, 4'b0001, 4'b0001, "bounce_6");
    // Speed select
    add(0, 4'b1000, 4, 0, 4'b0010, 4'b0010, "speed1_press");
    add(0, 4'b0000, 0, 5, 4'b0010, 4'b0010, "speed1_no_early_step");
    add(0, 4'b0000, 0, 1, 4'b0100, 4'b0100, "speed1_step_a");
    add(0, 4'b0000, 0, 7, 4'b0100, 4'b0100, "speed1_hold");
    add(0, 4'b0000, 0, 1, 4'b1000, 4'b1000, "speed1_step_b");
    add(0, 4'b1000, 4, 2, 4'b1000, 4'b1000, "speed2_press");
    add(0, 4'b1000, 4, 2, 4'b1000, 4'b1000, "speed3_press");
    add(0, 4'b1000, 4, 1, 4'b1000, 4'b1000, "speed0_press");
    add(0, 4'b0000, 0, 1, 4'b0100, 4'b0100, "speed0_step_a");
    add(0, 4'b0000, 0, 3, 4'b0100, 4'b0100, "speed0_hold");
    add(0, 4'b0000, 0, 1, 4'b0010, 4'b0010, "speed0_step_b");
    add(0, 4'b0000, 0, 4, 4'b0001, 4'b0001, "speed0_step_c");
    // Simultaneous SW1+SW2: no mode change, phase kept
    add(0, 4'b0011, 4, 0, 4'b0010, 4'b0010, "both_no_change");
    add(0, 4'b0000, 0, 2, 4'b0100, 4'b0100, "both_phase_kept");
    add(0, 4'b0000, 0, 3, 4'b0100, 4'b0100, "both_hold");
    add(0, 4'b0000, 0, 1, 4'b1000, 4'b1000, "both_step");
    // Pause
    add(0, 4'b0010, 4, 1, 4'b0001, 4'b0001, "to_chase");
    add(0, 4'b0100, 4, 0, 4'b0010, 4'b0010, "pause_on");
    add(0, 4'b0000, 0, 10, 4'b0010, 4'b0010, "paused_hold_a");
    add(0, 4'b0000, 0, 10, 4'b0010, 4'b0010, "paused_hold_b");
    add(0, 4'b0001, 4, 0, 4'b0001, 4'b0001, "paused_mode_load");
    add(0, 4'b0000, 0, 12, 4'b0001, 4'b0001, "paused_still");
    add(0, 4'b0100, 4, 3, 4'b0001, 4'b0001, "resume_before_step");
    add(0, 4'b0000, 0, 1, 4'b0010, 4'b0010, "resume_step");
    // Mode 0 (dark or heartbeat)
    add(0, 4'b0001, 4, 0, 4'b0000, 4'b0000, "off_entry");
    add(0, 4'b0000, 0, 3, 4'b0000, 4'b0000, "off_pre_step");
    add(0, 4'b0000, 0, 1, 4'b0000, 4'b1000, "off_step1");
    add(0, 4'b0000, 0, 4, 4'b0000, 4'b0000, "off_step2");
    add(0, 4'b0000, 0, 4, 4'b0000, 4'b1000, "off_step3");

    repeat (2) @(negedge i_Clk);
    check("reset_state", leds, 4'b0000);
    i_Rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) begin
        i_Rst = 1'b1;
        #1 check({vecs[i].name, "_async_clear"}, leds, 4'b0000);
        #1 i_Rst = 1'b0;
      end
      if (vecs[i].sw != 4'b0000) press(vecs[i].sw, vecs[i].hold);
      repeat (vecs[i].wait_cyc) @(negedge i_Clk);
`ifdef LED_SEQ_HEARTBEAT_EN
      exp = vecs[i].exp_hb;
`else
      exp = vecs[i].exp_dark;
`endif
      check(vecs[i].name, leds, exp);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: sequence did not complete, passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Front-panel controller for the board's four LEDs. It debounces the four push switches and uses them to select, pause and re-time one of four LED patterns. A shared prescaler (counter + terminal tick) paces the pattern steps. Sits directly between the top-level switch inputs and LED outputs, replacing free-running per-LED blink counters.

Parameters:
TICK_CLKS, 2500000, i_Clk cycles per base tick (100 ms at 25 MHz); legal range 2..2^31-1
DEBOUNCE_CLKS, 250000, consecutive stable cycles before a switch change is accepted (10 ms)

Ports:
i_Clk  input  1  system clock (25 MHz)
i_Rst  input  1  asynchronous, active-high reset
i_Switch_1  input  1  next mode (active-high, asynchronous to i_Clk)
i_Switch_2  input  1  previous mode
i_Switch_3  input  1  pause/run toggle
i_Switch_4  input  1  speed select
o_LED_1  output  1  pattern bit 0
o_LED_2  output  1  pattern bit 1
o_LED_3  output  1  pattern bit 2
o_LED_4  output  1  pattern bit 3

Behaviour:
- Reset: async and immediate. LEDs 0, mode 0, speed 0, run (not paused). All counters, synchronisers and debounced states 0.
- Input path per switch: 2-flop synchroniser, then debouncer. The debounce counter clears whenever the sync value equals the debounced state. When it reaches DEBOUNCE_CLKS-1 with the value still differing, the debounced state flips.
- A press is a 1-cycle pulse on a debounced 0->1 transition. Releases generate nothing.
- Mode register, 2 bits:
  - SW1 press: mode+1, wrapping 3->0.
  - SW2 press: mode-1, wrapping 0->3.
  - SW1 and SW2 presses in the same cycle: no change.
- Mode change actions, all on the same edge: load the mode's initial pattern, clear the prescaler, clear the rate counter.
- SW3 press: toggle pause. While paused, prescaler, rate counter and pattern all hold. A mode change while paused still loads the initial pattern and stays paused.
- SW4 press: speed = speed+1 mod 4; clear the rate counter. The prescaler is not cleared.
- Prescaler: counts 0..TICK_CLKS-1 and wraps. The wrap cycle asserts base_tick.
- Rate counter: counts base_ticks 0..2^speed-1. Asserts step on the base_tick that reaches the terminal value, then wraps.
- Step period: TICK_CLKS*2^speed cycles. The first step lands exactly one period after a mode change.
- Pattern register (bit0 = o_LED_1) updates on the edge where step is high. LEDs are driven directly from it (registered, no combinational path from switches).
  - Mode 0 OFF: 0000, steps ignored.
  - Mode 1 BLINK: initial 0000, invert on each step.
  - Mode 2 CHASE: initial 0001, rotate left on each step (1000->0001).
  - Mode 3 BOUNCE: initial 0001, one-hot ping-pong 0001,0010,0100,1000,0100,0010,0001,... A direction flag reverses at both ends; it is set to "up" on mode entry and on reset.
- Priority in a single cycle: reset > mode change > step. Pause and speed presses combine freely with the others.
- Switch-to-effect latency: 2 sync cycles + DEBOUNCE_CLKS + 1 edge for the register update.

Optional Feature:
LED_SEQ_HEARTBEAT_EN
- Defined: in mode 0, o_LED_4 toggles on each step (honouring pause and speed), while LEDs 1-3 stay 0. o_LED_4 clears to 0 on entry to mode 0.
- Undefined: mode 0 is fully dark, as specified above.

Test Plan:
(Bench uses TICK_CLKS=4, DEBOUNCE_CLKS=3.)
1. Reset, single press: run in mode 2 until LEDs=0100, then pulse i_Rst between clock edges. Expect all LEDs 0 before the next edge. Then press SW1 once. Expect mode 1 and LEDs 0000, then 1111 4 clocks later, then 0000 4 clocks after that.
2. Debounce: hold SW1 high for 2 cycles, then low. Expect no mode change, LEDs remain 0000. Repeat the test with a 6-cycle hold. Expect the mode to advance exactly once.
3. Bounce, speed: from mode 3, expect 0001,0010,0100,1000,0100,0010,0001 at 4-clock spacing. Press SW4. Expect subsequent steps at 8-clock spacing. After 3 more SW4 presses, expect 4-clock spacing again.
4. Mode wrap: from mode 0, press SW2. Expect mode 3 (LEDs 0001). Press SW1 and SW2 in the same cycle. Expect LEDs unchanged and no step-phase reset.
5. Pause: in mode 2 at LEDs=0010, press SW3. Expect LEDs held for ≥20 clocks. Press SW1 while paused. Expect 0001 loaded, still held. Press SW3 again. Expect 0010 exactly 4 clocks later.
6. Heartbeat: with LED_SEQ_HEARTBEAT_EN defined, in mode 0 expect o_LED_4 to toggle every 4 clocks and LEDs 1-3 to stay 0. With the macro undefined, expect all LEDs to stay 0.
